pipe_phy_ctrl_fsm: RTL and testbench

//  PHY-side control stage that consumes the MAC-driven PIPE control signals
//  (power_down, rate, tx_detect_rx, tx_elec_idle).
//  It produces the PHY responses on phy_status and rx_status, and sits directly

---
 rtl/pipe_phy_ctrl_fsm.sv | 157 +++++++++++++++
 tb/tb_pipe_phy_ctrl_fsm.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_phy_ctrl_fsm.sv
// PHY-side PIPE control FSM: sequences reset hold, power-state changes, rate changes
// and receiver detection, each finished by a single-cycle phy_status handshake.
module pipe_phy_ctrl_fsm #(
  parameter int RESET_ACK_CYCLES = 8,
  parameter int PD_LATENCY       = 4,
  parameter int RATE_LATENCY     = 16,
  parameter int DETECT_LATENCY   = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] power_down,
  input  logic [3:0] rate,
  input  logic       tx_detect_rx,
  input  logic [3:0] tx_elec_idle,
  input  logic       rx_present,
  output logic       phy_status,
  output logic [2:0] rx_status,
  output logic [3:0] pd_current,
  output logic [3:0] rate_current,
  output logic       busy,
  output logic       err_illegal
);

  localparam int MAX_A   = (PD_LATENCY > RATE_LATENCY) ? PD_LATENCY : RATE_LATENCY;
  localparam int MAX_B   = (DETECT_LATENCY > RESET_ACK_CYCLES) ? DETECT_LATENCY : RESET_ACK_CYCLES;
  localparam int MAX_LAT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;

  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RESET_ACK_CYCLES - 1);
  localparam logic [CNT_W-1:0] PD_LOAD   = CNT_W'(PD_LATENCY - 1);
  localparam logic [CNT_W-1:0] RATE_LOAD = CNT_W'(RATE_LATENCY - 1);
  localparam logic [CNT_W-1:0] DET_LOAD  = CNT_W'(DETECT_LATENCY - 1);

  localparam logic [3:0] PD_P1 = 4'd2;

  typedef enum logic [2:0] {
    S_RESET_HOLD,
    S_IDLE,
    S_PD_CHANGE,
    S_RATE_CHANGE,
    S_DETECT,
    S_ACK
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       pd_req_q;
  logic [3:0]       rate_req_q;
  logic [3:0]       pd_prev_q;
  logic             detect_armed_q;
  logic             phy_status_q;
  logic [2:0]       rx_status_q;
  logic [3:0]       pd_current_q;
  logic [3:0]       rate_current_q;
  logic             busy_q;
  logic             err_illegal_q;

  logic pd_legal;
  logic rate_req;
  logic pd_req;
  logic det_req;

  assign pd_legal = (power_down <= 4'd3);
  assign rate_req = (rate != rate_current_q);
  assign pd_req   = pd_legal && (power_down != pd_current_q);
  assign det_req  = tx_detect_rx && detect_armed_q && (pd_current_q == PD_P1) && tx_elec_idle[0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_RESET_HOLD;
      cnt_q          <= '0;
      pd_req_q       <= PD_P1;
      rate_req_q     <= 4'd0;
      pd_prev_q      <= 4'd0;
      detect_armed_q <= 1'b1;
      phy_status_q   <= 1'b1;
      rx_status_q    <= 3'b000;
      pd_current_q   <= PD_P1;
      rate_current_q <= 4'd0;
      busy_q         <= 1'b1;
      err_illegal_q  <= 1'b0;
    end else begin
      // Illegal power_down is flagged once, on the first sample of a new illegal value.
      pd_prev_q     <= power_down;
      err_illegal_q <= (state_q != S_RESET_HOLD) && !pd_legal && (power_down != pd_prev_q);

      if (!tx_detect_rx) detect_armed_q <= 1'b1;

      case (state_q)
        S_RESET_HOLD: begin
          if (cnt_q == RST_LAST) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            phy_status_q <= 1'b0;
            busy_q       <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        S_IDLE: begin
          if (rate_req) begin
            state_q    <= S_RATE_CHANGE;
            cnt_q      <= RATE_LOAD;
            rate_req_q <= rate;
            busy_q     <= 1'b1;
          end else if (pd_req) begin
            state_q  <= S_PD_CHANGE;
            cnt_q    <= PD_LOAD;
            pd_req_q <= power_down;
            busy_q   <= 1'b1;
          end else if (det_req) begin
            state_q        <= S_DETECT;
            cnt_q          <= DET_LOAD;
            detect_armed_q <= 1'b0;
            busy_q         <= 1'b1;
          end
        end

        S_PD_CHANGE, S_RATE_CHANGE, S_DETECT: begin
          // Counter reaches zero exactly LAT edges after the sampling edge in IDLE.
          if (cnt_q == '0) begin
            state_q      <= S_ACK;
            phy_status_q <= 1'b1;
            if (state_q == S_PD_CHANGE)   pd_current_q   <= pd_req_q;
            if (state_q == S_RATE_CHANGE) rate_current_q <= rate_req_q;
            if (state_q == S_DETECT)      rx_status_q    <= rx_present ? 3'b011 : 3'b000;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        S_ACK: begin
          state_q      <= S_IDLE;
          phy_status_q <= 1'b0;
          rx_status_q  <= 3'b000;
          busy_q       <= 1'b0;
        end

        default: begin
          state_q      <= S_RESET_HOLD;
          cnt_q        <= '0;
          phy_status_q <= 1'b1;
          busy_q       <= 1'b1;
        end
      endcase
    end
  end

  assign phy_status   = phy_status_q;
  assign rx_status    = rx_status_q;
  assign pd_current   = pd_current_q;
  assign rate_current = rate_current_q;
  assign busy         = busy_q;
  assign err_illegal  = err_illegal_q;

endmodule

// File: tb/tb_pipe_phy_ctrl_fsm.sv
// Scoreboard bench for pipe_phy_ctrl_fsm: stimulus queues expected phy_status / err_illegal
// events with hand-computed cycles; a monitor pops and compares as the DUT produces them.
module tb_pipe_phy_ctrl_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] power_down = 4'd2;
  logic [3:0] rate = 4'd0;
  logic       tx_detect_rx = 1'b0;
  logic [3:0] tx_elec_idle = 4'hF;
  logic       rx_present = 1'b0;
  logic       phy_status;
  logic [2:0] rx_status;
  logic [3:0] pd_current;
  logic [3:0] rate_current;
  logic       busy;
  logic       err_illegal;

  pipe_phy_ctrl_fsm dut (
    .clk          (clk),
    .reset        (reset),
    .power_down   (power_down),
    .rate         (rate),
    .tx_detect_rx (tx_detect_rx),
    .tx_elec_idle (tx_elec_idle),
    .rx_present   (rx_present),
    .phy_status   (phy_status),
    .rx_status    (rx_status),
    .pd_current   (pd_current),
    .rate_current (rate_current),
    .busy         (busy),
    .err_illegal  (err_illegal)
  );

  always #5 clk = ~clk;

  // cyc == k after the k-th rising edge
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int K_HOLD  = 0;
  localparam int K_PULSE = 1;
  localparam int K_ILL   = 2;

  typedef struct {
    int kind;
    int cyc;
    int pd;
    int rate;
    int rx;
    int busy;
  } ev_t;

  ev_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;

  function automatic ev_t mk(int kind, int c, int pd, int rt, int rx, int b);
    ev_t e;
    e.kind = kind; e.cyc = c; e.pd = pd; e.rate = rt; e.rx = rx; e.busy = b;
    return e;
  endfunction

  function automatic string kname(int k);
    case (k)
      K_HOLD:  return "reset_hold_end";
      K_PULSE: return "status_pulse";
      default: return "err_illegal";
    endcase
  endfunction

  task automatic chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic expect_ev(int kind, int c, int pd, int rt, int rx, int b);
    exp_q.push_back(mk(kind, c, pd, rt, rx, b));
  endtask

  task automatic compare(ev_t a);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_%s actual cyc=%0d pd=%0d rate=%0d rx=%0d busy=%0d required no event",
               kname(a.kind), a.cyc, a.pd, a.rate, a.rx, a.busy);
    end else begin
      e = exp_q.pop_front();
      if (a.kind != e.kind || a.cyc != e.cyc || a.pd != e.pd || a.rate != e.rate ||
          a.rx != e.rx || a.busy != e.busy) begin
        failures++;
        $display("FAIL %s actual=%s cyc=%0d pd=%0d rate=%0d rx=%0d busy=%0d required=%s cyc=%0d pd=%0d rate=%0d rx=%0d busy=%0d",
                 kname(e.kind), kname(a.kind), a.cyc, a.pd, a.rate, a.rx, a.busy,
                 kname(e.kind), e.cyc, e.pd, e.rate, e.rx, e.busy);
      end
    end
  endtask

  // Monitor: classifies phy_status high runs (1 cycle = pulse, longer = reset hold) and err pulses.
  initial begin : monitor
    logic prev;
    int   run;
    ev_t  hi;
    prev = 1'b0;
    run  = 0;
    hi   = mk(K_PULSE, 0, 0, 0, 0, 0);
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        prev = 1'b1;
        run  = 2;
      end else begin
        if (err_illegal)
          compare(mk(K_ILL, cyc, pd_current, rate_current, rx_status, busy));
        if (phy_status) begin
          if (!prev) begin
            hi  = mk(K_PULSE, cyc, pd_current, rate_current, rx_status, busy);
            run = 1;
          end else begin
            run++;
          end
        end else if (prev) begin
          if (run == 1) compare(hi);
          else compare(mk(K_HOLD, cyc, pd_current, rate_current, rx_status, busy));
        end
        prev = phy_status;
      end
    end
  end

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin : stim
    int  k;
    ev_t e;

    // T1: reset hold and release
    step(5);
    chk("reset_phy_status", phy_status, 1);
    chk("reset_rx_status", rx_status, 0);
    chk("reset_pd_current", pd_current, 2);
    chk("reset_rate_current", rate_current, 0);
    chk("reset_busy", busy, 1);
    chk("reset_err_illegal", err_illegal, 0);
    reset = 1'b1;
    k = cyc;
    expect_ev(K_HOLD, k + 8, 2, 0, 0, 0);
    step(12);

    // T2: P1 -> P0
    power_down = 4'd0;
    k = cyc;
    expect_ev(K_PULSE, k + 5, 0, 0, 0, 1);
    step(10);
    chk("p0_pd_current", pd_current, 0);
    chk("p0_busy", busy, 0);

    // T3: back to P1, then detect with and without a receiver
    power_down = 4'd2;
    k = cyc;
    expect_ev(K_PULSE, k + 5, 2, 0, 0, 1);
    step(10);
    tx_detect_rx = 1'b1;
    rx_present   = 1'b1;
    k = cyc;
    expect_ev(K_PULSE, k + 13, 2, 0, 3, 1);
    step(40);
    tx_detect_rx = 1'b0;
    step(3);
    rx_present   = 1'b0;
    tx_detect_rx = 1'b1;
    k = cyc;
    expect_ev(K_PULSE, k + 13, 2, 0, 0, 1);
    step(20);
    tx_detect_rx = 1'b0;
    step(3);

    // T4: rate wins priority; power_down changed while busy is handled afterwards
    rate       = 4'd2;
    power_down = 4'd0;
    k = cyc;
    expect_ev(K_PULSE, k + 17, 2, 2, 0, 1);
    step(5);
    power_down = 4'd3;
    expect_ev(K_PULSE, k + 23, 3, 2, 0, 1);
    step(25);
    chk("t4_pd_current", pd_current, 3);

    // T5: illegal power_down in IDLE, then while busy
    power_down = 4'h5;
    k = cyc;
    expect_ev(K_ILL, k + 1, 3, 2, 0, 0);
    step(6);
    chk("t5_pd_current", pd_current, 3);
    chk("t5_busy", busy, 0);
    power_down = 4'd3;
    step(3);
    rate = 4'd4;
    k = cyc;
    step(3);
    power_down = 4'h7;
    expect_ev(K_ILL, k + 4, 3, 2, 0, 1);
    expect_ev(K_PULSE, k + 17, 3, 4, 0, 1);
    step(20);
    power_down = 4'd3;
    step(3);

    // T6: reset asserted mid-detect
    power_down = 4'd2;
    k = cyc;
    expect_ev(K_PULSE, k + 5, 2, 4, 0, 1);
    step(10);
    tx_detect_rx = 1'b1;
    rx_present   = 1'b1;
    step(6);
    reset = 1'b0;
    #1;
    chk("t6_phy_status", phy_status, 1);
    chk("t6_rx_status", rx_status, 0);
    chk("t6_busy", busy, 1);
    chk("t6_pd_current", pd_current, 2);
    chk("t6_rate_current", rate_current, 0);
    rate         = 4'd0;
    tx_detect_rx = 1'b0;
    step(5);
    reset = 1'b1;
    k = cyc;
    expect_ev(K_HOLD, k + 8, 2, 0, 0, 0);
    step(12);
    power_down = 4'd0;
    k = cyc;
    expect_ev(K_PULSE, k + 5, 0, 0, 0, 1);
    step(12);

    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      failures++;
      $display("FAIL missing_%s actual=none required cyc=%0d pd=%0d rate=%0d rx=%0d",
               kname(e.kind), e.cyc, e.pd, e.rate, e.rx);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
